// File: rtl/sd_fifo_head_b.sv
// Write-side controller for the big memory-based FIFO: zero-latency srdy/drdy accept,
// windowed write pointer with non-power-of-2 wrap, optional commit/abort publication.
module sd_fifo_head_b #(
    parameter int width  = 8,
    parameter int depth  = 16,
    parameter int commit = 0,
    parameter int asz    = $clog2(depth)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             c_srdy,
    output logic             c_drdy,
    input  logic             c_commit,
    input  logic             c_abort,
    input  logic [width-1:0] c_data,
    input  logic [asz-1:0]   bound_low,
    input  logic [asz-1:0]   bound_high,
    input  logic [asz-1:0]   rdptr,
    output logic [asz-1:0]   cur_wrptr,
    output logic [asz-1:0]   com_wrptr,
    output logic             mem_we,
    output logic [asz-1:0]   mem_wraddr,
    output logic [width-1:0] mem_wrdata,
    output logic [asz:0]     usage
);

    logic [asz-1:0] cur_wrptr_p1;
    logic [asz-1:0] com_reg;
    logic [asz:0]   fifo_size;
    logic           full;
    logic           do_abort;
    logic           do_commit;
    logic           xfer;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        cur_wrptr_p1 = cur_wrptr + asz'(1);
        if (cur_wrptr == bound_high)
            cur_wrptr_p1 = bound_low;

        do_abort  = (commit != 0) && c_abort;
        do_commit = (commit != 0) && c_commit;
        full      = (cur_wrptr_p1 == rdptr);
        c_drdy    = enable && !full && !do_abort;
        xfer      = c_srdy && c_drdy;

        mem_we     = xfer;
        mem_wraddr = cur_wrptr;
        mem_wrdata = c_data;
        com_wrptr  = (commit != 0) ? com_reg : cur_wrptr;
    end

    // Window size may be any value up to depth, so usage wraps by the window, not by 2**asz.
    always_comb begin
        fifo_size = {1'b0, bound_high} - {1'b0, bound_low} + (asz+1)'(1);
        usage     = {1'b0, cur_wrptr} - {1'b0, rdptr};
        if (cur_wrptr < rdptr)
            usage = fifo_size - ({1'b0, rdptr} - {1'b0, cur_wrptr});
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_wrptr <= bound_low;
            com_reg   <= bound_low;
        end else if (do_abort) begin
            cur_wrptr <= com_reg;
        end else begin
            if (xfer)
                cur_wrptr <= cur_wrptr_p1;
            if (do_commit)
                com_reg <= xfer ? cur_wrptr_p1 : cur_wrptr;
        end
    end

endmodule

// File: tb/tb_sd_fifo_head_b.sv
// Self-checking bench: a commit=0 and a commit=1 head share the same stimulus and are
// compared every cycle against a modular-arithmetic model of the write window.
module tb_sd_fifo_head_b;

    logic       clk = 1'b0;
    logic       reset, enable, c_srdy, c_commit, c_abort;
    logic [7:0] c_data;
    logic [3:0] bound_low, bound_high, rdptr;

    logic       c_drdy0, mem_we0, c_drdy1, mem_we1;
    logic [3:0] cur_wrptr0, com_wrptr0, mem_wraddr0, cur_wrptr1, com_wrptr1, mem_wraddr1;
    logic [7:0] mem_wrdata0, mem_wrdata1;
    logic [4:0] usage0, usage1;

    int n_cmp = 0;
    int n_mis = 0;

    // model state: dut0 has only a write pointer, dut1 has speculative and published pointers
    int m_cur0, m_cur1, m_com1;

    always #5 clk = ~clk;

    sd_fifo_head_b #(.width(8), .depth(16), .commit(0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .c_srdy(c_srdy), .c_drdy(c_drdy0),
        .c_commit(c_commit), .c_abort(c_abort), .c_data(c_data),
        .bound_low(bound_low), .bound_high(bound_high), .rdptr(rdptr),
        .cur_wrptr(cur_wrptr0), .com_wrptr(com_wrptr0), .mem_we(mem_we0),
        .mem_wraddr(mem_wraddr0), .mem_wrdata(mem_wrdata0), .usage(usage0)
    );

    sd_fifo_head_b #(.width(8), .depth(16), .commit(1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .c_srdy(c_srdy), .c_drdy(c_drdy1),
        .c_commit(c_commit), .c_abort(c_abort), .c_data(c_data),
        .bound_low(bound_low), .bound_high(bound_high), .rdptr(rdptr),
        .cur_wrptr(cur_wrptr1), .com_wrptr(com_wrptr1), .mem_we(mem_we1),
        .mem_wraddr(mem_wraddr1), .mem_wrdata(mem_wrdata1), .usage(usage1)
    );

    wire [26:0] obs0 = {c_drdy0, mem_we0, mem_wraddr0, cur_wrptr0, com_wrptr0, usage0, mem_wrdata0};
    wire [26:0] obs1 = {c_drdy1, mem_we1, mem_wraddr1, cur_wrptr1, com_wrptr1, usage1, mem_wrdata1};

    function automatic int win_size();
        return int'(bound_high) - int'(bound_low) + 1;
    endfunction

    function automatic int nxt(int p);
        return int'(bound_low) + ((p - int'(bound_low) + 1) % win_size());
    endfunction

    function automatic int occ(int p);
        return (p - int'(rdptr) + win_size()) % win_size();
    endfunction

    function automatic logic [26:0] exp0();
        logic drdy;
        drdy = enable && (nxt(m_cur0) != int'(rdptr));
        return {drdy, c_srdy && drdy, 4'(m_cur0), 4'(m_cur0), 4'(m_cur0), 5'(occ(m_cur0)), c_data};
    endfunction

    function automatic logic [26:0] exp1();
        logic drdy;
        drdy = enable && (nxt(m_cur1) != int'(rdptr)) && !c_abort;
        return {drdy, c_srdy && drdy, 4'(m_cur1), 4'(m_cur1), 4'(m_com1), 5'(occ(m_cur1)), c_data};
    endfunction

    task automatic drive(input logic s, input logic cm, input logic ab, input logic [7:0] d);
        c_srdy   = s;
        c_commit = cm;
        c_abort  = ab;
        c_data   = d;
        #1;
    endtask

    // advance one clock and move the model by the same edge
    task automatic step();
        int  n0, n1;
        logic we0, we1, ab, cm, rst;
        n0  = nxt(m_cur0);
        n1  = nxt(m_cur1);
        ab  = c_abort;
        cm  = c_commit;
        rst = reset;
        we0 = c_srdy && enable && (n0 != int'(rdptr));
        we1 = c_srdy && enable && (n1 != int'(rdptr)) && !ab;
        @(posedge clk);
        if (rst) begin
            m_cur0 = int'(bound_low);
            m_cur1 = int'(bound_low);
            m_com1 = int'(bound_low);
        end else begin
            if (we0) m_cur0 = n0;
            if (ab) begin
                m_cur1 = m_com1;
            end else begin
                if (cm) m_com1 = we1 ? n1 : m_cur1;
                if (we1) m_cur1 = n1;
            end
        end
        #2;
    endtask

    task automatic do_reset(input logic [3:0] bl, input logic [3:0] bh, input logic [3:0] rp);
        reset      = 1'b1;
        bound_low  = bl;
        bound_high = bh;
        rdptr      = rp;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        do_reset(4'd0, 4'd15, 4'd0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        n_cmp++;
        if (obs0 !== exp0() || obs1 !== exp1()) begin
            n_mis++;
            $display("FAIL reset: got %h/%h want %h/%h", obs0, obs1, exp0(), exp1());
        end
        n_cmp++;
        if (usage1 !== 5'd0 || c_drdy1 !== 1'b1 || cur_wrptr0 !== 4'd0) begin
            n_mis++;
            $display("FAIL reset_const: usage=%0d drdy=%b cur=%0d want 0 1 0", usage1, c_drdy1, cur_wrptr0);
        end
    endtask

    task automatic test_fill();
        int accepted = 0;
        int bad_addr = 0;
        do_reset(4'd0, 4'd15, 4'd0);
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(i));
            n_cmp++;
            if (obs0 !== exp0() || obs1 !== exp1()) begin
                n_mis++;
                $display("FAIL fill cyc%0d: got %h/%h want %h/%h", i, obs0, obs1, exp0(), exp1());
            end
            if (mem_we0 === 1'b1) accepted++;
            if (mem_we0 === 1'b1 && mem_wraddr0 === 4'd15) bad_addr++;
            step();
        end
        drive(1'b1, 1'b0, 1'b0, 8'd21);
        n_cmp++;
        if (accepted != 15 || bad_addr != 0 || usage0 !== 5'd15 || c_drdy0 !== 1'b0) begin
            n_mis++;
            $display("FAIL fill_full: accepted=%0d at15=%0d usage=%0d drdy=%b want 15 0 15 0",
                     accepted, bad_addr, usage0, c_drdy0);
        end
    endtask

    task automatic test_wrap();
        do_reset(4'd3, 4'd8, 4'd3);
        for (int i = 0; i < 7; i++) begin
            if (i == 5) begin
                drive(1'b0, 1'b0, 1'b0, 8'h00);
                n_cmp++;
                if (cur_wrptr0 !== 4'd8 || c_drdy0 !== 1'b0) begin
                    n_mis++;
                    $display("FAIL wrap_full: cur=%0d drdy=%b want 8 0", cur_wrptr0, c_drdy0);
                end
                rdptr = 4'd5;
            end
            drive(1'b1, 1'b0, 1'b0, 8'(8'hA0 + i));
            n_cmp++;
            if (obs0 !== exp0() || obs1 !== exp1()) begin
                n_mis++;
                $display("FAIL wrap cyc%0d: got %h/%h want %h/%h", i, obs0, obs1, exp0(), exp1());
            end
            if (i == 6) begin
                n_cmp++;
                if (mem_we0 !== 1'b1 || mem_wraddr0 !== 4'd3) begin
                    n_mis++;
                    $display("FAIL wrap_addr: we=%b addr=%0d want 1 3", mem_we0, mem_wraddr0);
                end
            end
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        n_cmp++;
        if (cur_wrptr0 !== 4'd4 || usage0 !== 5'd5) begin
            n_mis++;
            $display("FAIL wrap_end: cur=%0d usage=%0d want 4 5", cur_wrptr0, usage0);
        end
    endtask

    task automatic test_usage();
        do_reset(4'd0, 4'd9, 4'd0);
        for (int i = 0; i < 12; i++) begin
            if (i == 7) rdptr = 4'd7;
            drive(1'b1, 1'b0, 1'b0, 8'(i));
            n_cmp++;
            if (obs0 !== exp0() || obs1 !== exp1()) begin
                n_mis++;
                $display("FAIL usage cyc%0d: got %h/%h want %h/%h", i, obs0, obs1, exp0(), exp1());
            end
            if (i == 7) begin
                n_cmp++;
                if (cur_wrptr0 !== 4'd7 || usage0 !== 5'd0) begin
                    n_mis++;
                    $display("FAIL usage_zero: cur=%0d usage=%0d want 7 0", cur_wrptr0, usage0);
                end
            end
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        n_cmp++;
        if (cur_wrptr0 !== 4'd2 || usage0 !== 5'd5) begin
            n_mis++;
            $display("FAIL usage_wrap: cur=%0d usage=%0d want 2 5", cur_wrptr0, usage0);
        end
    endtask

    task automatic test_commit_abort();
        do_reset(4'd0, 4'd15, 4'd0);
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, i == 3, i == 7, 8'(8'h40 + i));
            n_cmp++;
            if (obs0 !== exp0() || obs1 !== exp1()) begin
                n_mis++;
                $display("FAIL commit_abort cyc%0d: got %h/%h want %h/%h", i, obs0, obs1, exp0(), exp1());
            end
            if (i == 7) begin
                n_cmp++;
                if (mem_we1 !== 1'b0 || c_drdy1 !== 1'b0 || cur_wrptr1 !== 4'd7 || com_wrptr1 !== 4'd4) begin
                    n_mis++;
                    $display("FAIL abort_cycle: we=%b drdy=%b cur=%0d com=%0d want 0 0 7 4",
                             mem_we1, c_drdy1, cur_wrptr1, com_wrptr1);
                end
            end
            if (i == 8) begin
                n_cmp++;
                if (mem_we1 !== 1'b1 || mem_wraddr1 !== 4'd4 || com_wrptr1 !== 4'd4) begin
                    n_mis++;
                    $display("FAIL after_abort: we=%b addr=%0d com=%0d want 1 4 4", mem_we1, mem_wraddr1, com_wrptr1);
                end
            end
            step();
        end
    endtask

    task automatic test_commit_full();
        do_reset(4'd0, 4'd15, 4'd0);
        for (int i = 0; i < 19; i++) begin
            drive(1'b1, i == 2 || i == 3, i == 2, 8'(8'h80 + i));
            n_cmp++;
            if (obs0 !== exp0() || obs1 !== exp1()) begin
                n_mis++;
                $display("FAIL commit_full cyc%0d: got %h/%h want %h/%h", i, obs0, obs1, exp0(), exp1());
            end
            step();
            if (i == 2) begin
                n_cmp++;
                if (com_wrptr1 !== 4'd0 || cur_wrptr1 !== 4'd0) begin
                    n_mis++;
                    $display("FAIL abort_wins: com=%0d cur=%0d want 0 0", com_wrptr1, cur_wrptr1);
                end
            end
            if (i == 3) begin
                n_cmp++;
                if (com_wrptr1 !== 4'd1) begin
                    n_mis++;
                    $display("FAIL commit_xfer: com=%0d want 1", com_wrptr1);
                end
            end
        end
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        n_cmp++;
        if (cur_wrptr1 !== 4'd15 || com_wrptr1 !== 4'd1 || c_drdy1 !== 1'b0) begin
            n_mis++;
            $display("FAIL uncommitted_full: cur=%0d com=%0d drdy=%b want 15 1 0", cur_wrptr1, com_wrptr1, c_drdy1);
        end
    endtask

    task automatic test_enable_reset();
        do_reset(4'd0, 4'd15, 4'd0);
        for (int i = 0; i < 9; i++) begin
            enable = !(i >= 3 && i < 6);
            drive(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
            n_cmp++;
            if (obs0 !== exp0() || obs1 !== exp1()) begin
                n_mis++;
                $display("FAIL enable cyc%0d: got %h/%h want %h/%h", i, obs0, obs1, exp0(), exp1());
            end
            if (!enable) begin
                n_cmp++;
                if (c_drdy0 !== 1'b0 || mem_we0 !== 1'b0 || cur_wrptr0 !== 4'd3) begin
                    n_mis++;
                    $display("FAIL stall: drdy=%b we=%b cur=%0d want 0 0 3", c_drdy0, mem_we0, cur_wrptr0);
                end
            end
            step();
        end
        enable = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        n_cmp++;
        if (cur_wrptr0 !== 4'd6) begin
            n_mis++;
            $display("FAIL pre_reset: cur=%0d want 6", cur_wrptr0);
        end
        do_reset(4'd2, 4'd15, 4'd5);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        n_cmp++;
        if (cur_wrptr0 !== 4'd2 || com_wrptr1 !== 4'd2 || cur_wrptr1 !== 4'd2 || usage0 !== 5'd11) begin
            n_mis++;
            $display("FAIL mid_reset: cur0=%0d cur1=%0d com1=%0d usage=%0d want 2 2 2 11",
                     cur_wrptr0, cur_wrptr1, com_wrptr1, usage0);
        end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 6; seg++) begin
            logic [3:0] bl, bh;
            bl = 4'($urandom_range(0, 13));
            bh = 4'($urandom_range(int'(bl) + 1, 15));
            do_reset(bl, bh, bl);
            for (int i = 0; i < 80; i++) begin
                enable = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 1) == 1 && int'(rdptr) != m_com1 && int'(rdptr) != m_cur0)
                    rdptr = 4'(nxt(int'(rdptr)));
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                      $urandom_range(0, 9) == 0, 8'($urandom));
                n_cmp++;
                if (obs0 !== exp0() || obs1 !== exp1()) begin
                    n_mis++;
                    $display("FAIL random seg%0d cyc%0d: got %h/%h want %h/%h",
                             seg, i, obs0, obs1, exp0(), exp1());
                end
                step();
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; c_srdy = 1'b0; c_commit = 1'b0; c_abort = 1'b0;
        c_data = 8'h00; bound_low = 4'd0; bound_high = 4'd15; rdptr = 4'd0;
        m_cur0 = 0; m_cur1 = 0; m_com1 = 0;
        @(posedge clk);
        #2;
        test_reset();
        test_fill();
        test_wrap();
        test_usage();
        test_commit_abort();
        test_commit_full();
        test_enable_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
